sample_iterator: RTL and testbench
==================================

// Module: sample_iterator
// PURPOSE
//  Sample-position generator that feeds the jitter/hash stage. Accepts one triangle plus its
//  bounding box per handshake and walks the box in raster order at the subsample pitch.
//  Emits SAMPLES adjacent sample positions per cycle, each with its own valid bit, on the
//  R14 interface. Holds upstream off with halt_RnnnnL while a box is being walked.
// PARAMETERS
//  SIGFIG   24  fixed-point word width (bits)
//  RADIX    10  fractional bits; 1.0 pixel = 1<<RADIX
//  VERTS     3  triangle vertices
//  AXIS      3  coordinates per vertex
//  COLORS    3  colour channels
//  SAMPLES   2  sample lanes emitted per cycle (>=1)
// PORTS
//  clk               in   1                  clock; all state on rising edge
//  rst               in   1                  reset; asynchronous, active-low
//  tri_R13S          in   SIGFIG[VERTS][AXIS] triangle, signed
//  color_R13U        in   SIGFIG[COLORS]      triangle colour
//  box_R13S          in   SIGFIG[2][2]        bbox: [0]=lower-left, [1]=upper-right; [*][0]=x, [*][1]=y
//  validTri_R13H     in   1                  tri/box valid this cycle
//  subSample_RnnnnU  in   4                  one-hot: [3]=MSAA1 [2]=MSAA4 [1]=MSAA16 [0]=MSAA64
//  halt_RnnnnL       out  1                  1 = ready to accept; 0 = busy walking a box
//  tri_R14S          out  SIGFIG[VERTS][AXIS] latched triangle
//  color_R14U        out  SIGFIG[COLORS]      latched colour
//  sample_R14S       out  SIGFIG[SAMPLES][2]  sample lane positions; [i][0]=x, [i][1]=y
//  validSamp_R14H    out  1[SAMPLES]          per-lane valid
// BEHAVIOUR
//  Reset (rst=0, async): state=WAIT. All R14 outputs=0. halt_RnnnnL=1.
//  Step: MSAA1=1<<RADIX, MSAA4=1<<(RADIX-1), MSAA16=1<<(RADIX-2), MSAA64=1<<(RADIX-3).
//   subSample is sampled only at acceptance and held for the whole box.
//  All coordinate arithmetic and compares are SIGFIG-bit signed. Box coords are step-aligned
//   and on-screen, so no overflow handling is required.
//  FSM states: WAIT, TEST. halt_RnnnnL = (state==WAIT), driven from the state register.
//  WAIT:
//   - validTri_R13H=1 with llx<=urx and lly<=ury: accept.
//     - Latch tri, colour, box and step.
//     - Next cycle: tri_R14S, color_R14U and lane positions are driven.
//     - Lane i = (llx + i*step, lly); validSamp[i] = (llx + i*step <= urx).
//     - state -> TEST.
//   - validTri_R13H=1 with llx>urx or lly>ury: triangle consumed and dropped; stays in WAIT;
//     no valid samples.
//   - validSamp_R14H is all-zero whenever the state is WAIT.
//  TEST: each cycle one lane group is presented. The next group is chosen as follows:
//   - x0 + SAMPLES*step <= urx: x0 += SAMPLES*step (same row).
//   - else if y + step <= ury: x0 = llx, y += step (next row).
//   - else: the current group is the last. Next cycle: state=WAIT, validSamp all 0,
//     halt_RnnnnL=1.
//   - Lane valids are recomputed per group as (x0 + i*step <= urx).
//  Latency: first group 1 cycle after acceptance. Group count = rows * ceil(cols/SAMPLES).
//  Between boxes: one WAIT cycle minimum. validTri held high is accepted in that cycle.
//  tri_R14S and color_R14U hold their latched values through TEST and WAIT until the next
//   acceptance.
//  sample_R14S holds its last value in WAIT. Only validSamp qualifies it.
//  Reset mid-TEST: immediate abort, reset values as above. The in-flight triangle is lost.
// TESTING (RADIX=10, SAMPLES=2)
//  1 MSAA1, box (0,0)-(1024,0) -> 1 group: x={0,1024}, y=0, valid=11; then WAIT, halt=1.
//  2 MSAA1, box (0,0)-(2048,1024) -> 4 groups in order:
//    x{0,1024}/y0 v11, x{2048,3072}/y0 v10, x{0,1024}/y1024 v11, x{2048,3072}/y1024 v10.
//  3 MSAA4 (4'b0100), box (0,0)-(512,512) -> groups x{0,512}/y0 v11, x{0,512}/y512 v11;
//    halt low for exactly 2 cycles.
//  4 validTri held high for two triangles -> second accepted in the single WAIT cycle
//    after the first box's last group; no group dropped or duplicated.
//  5 rst=0 during group 2 of scenario 2 -> same cycle: validSamp=00, halt=1, outputs 0;
//    after release, a new triangle is walked from its ll corner.
//  6 box (2048,0)-(1024,0) -> stays WAIT, halt stays 1, validSamp stays 00.

Source files
------------

// File: rtl/sample_iterator_if.sv
// Bundle between the triangle setup stage (master) and the sample iterator (slave).
// Valid/ready rule: a triangle transfers on the rising edge where validTri_R13H=1 and halt_RnnnnL=1.
interface sample_iterator_if #(
  parameter int SIGFIG  = 24,
  parameter int VERTS   = 3,
  parameter int AXIS    = 3,
  parameter int COLORS  = 3,
  parameter int SAMPLES = 2
);
  logic signed [SIGFIG-1:0] tri_R13S [VERTS][AXIS];
  logic [SIGFIG-1:0]        color_R13U [COLORS];
  logic signed [SIGFIG-1:0] box_R13S [2][2];
  logic                     validTri_R13H;
  logic [3:0]               subSample_RnnnnU;
  logic                     halt_RnnnnL;
  logic signed [SIGFIG-1:0] tri_R14S [VERTS][AXIS];
  logic [SIGFIG-1:0]        color_R14U [COLORS];
  logic signed [SIGFIG-1:0] sample_R14S [SAMPLES][2];
  logic [SAMPLES-1:0]       validSamp_R14H;
  // FSM state for observation: 0 = WAIT, 1 = TEST
  logic                     state_dbg;

  modport master (
    output tri_R13S, color_R13U, box_R13S, validTri_R13H, subSample_RnnnnU,
    input  halt_RnnnnL, tri_R14S, color_R14U, sample_R14S, validSamp_R14H, state_dbg
  );

  modport slave (
    input  tri_R13S, color_R13U, box_R13S, validTri_R13H, subSample_RnnnnU,
    output halt_RnnnnL, tri_R14S, color_R14U, sample_R14S, validSamp_R14H, state_dbg
  );
endinterface

// File: rtl/sample_iterator.sv
// Walks a triangle's bounding box in raster order at the subsample pitch,
// emitting SAMPLES horizontally adjacent sample positions per cycle.
module sample_iterator #(
  parameter int SIGFIG  = 24,
  parameter int RADIX   = 10,
  parameter int VERTS   = 3,
  parameter int AXIS    = 3,
  parameter int COLORS  = 3,
  parameter int SAMPLES = 2
) (
  input  logic         clk,
  input  logic         rst,
  sample_iterator_if.slave bus
);

  typedef enum logic {WAIT = 1'b0, TEST = 1'b1} state_t;

  localparam logic signed [SIGFIG-1:0] STEP1  = SIGFIG'(1 << RADIX);
  localparam logic signed [SIGFIG-1:0] STEP4  = SIGFIG'(1 << (RADIX - 1));
  localparam logic signed [SIGFIG-1:0] STEP16 = SIGFIG'(1 << (RADIX - 2));
  localparam logic signed [SIGFIG-1:0] STEP64 = SIGFIG'(1 << (RADIX - 3));

  state_t state, state_nxt;

  logic signed [SIGFIG-1:0] tri_q [VERTS][AXIS];
  logic [SIGFIG-1:0]        color_q [COLORS];
  logic signed [SIGFIG-1:0] llx_q, urx_q, ury_q, step_q;
  logic signed [SIGFIG-1:0] x0_q, y_q, x0_nxt, y_nxt;
  logic signed [SIGFIG-1:0] step_in;
  logic signed [SIGFIG-1:0] lane_x [SAMPLES];
  logic signed [SIGFIG-1:0] next_x0, next_y;
  logic                     box_ok, accept;

  assign box_ok = (bus.box_R13S[0][0] <= bus.box_R13S[1][0]) &&
                  (bus.box_R13S[0][1] <= bus.box_R13S[1][1]);
  assign accept = (state == WAIT) && bus.validTri_R13H && box_ok;

  always_comb begin
    step_in = STEP1;
    case (bus.subSample_RnnnnU)
      4'b1000: step_in = STEP1;
      4'b0100: step_in = STEP4;
      4'b0010: step_in = STEP16;
      4'b0001: step_in = STEP64;
      default: step_in = STEP1;
    endcase
  end

  // Lane positions are a running sum so no multiplier is needed; the group
  // advance is simply one more step past the last lane.
  always_comb begin
    lane_x[0] = x0_q;
    for (int i = 1; i < SAMPLES; i++) begin
      lane_x[i] = lane_x[i-1] + step_q;
    end
  end

  assign next_x0 = lane_x[SAMPLES-1] + step_q;
  assign next_y  = y_q + step_q;

  always_comb begin
    state_nxt = state;
    x0_nxt    = x0_q;
    y_nxt     = y_q;
    case (state)
      WAIT: begin
        if (accept) begin
          state_nxt = TEST;
          x0_nxt    = bus.box_R13S[0][0];
          y_nxt     = bus.box_R13S[0][1];
        end
      end
      TEST: begin
        if (next_x0 <= urx_q) begin
          x0_nxt = next_x0;
        end else if (next_y <= ury_q) begin
          x0_nxt = llx_q;
          y_nxt  = next_y;
        end else begin
          state_nxt = WAIT;
        end
      end
      default: state_nxt = WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= WAIT;
      x0_q   <= '0;
      y_q    <= '0;
      llx_q  <= '0;
      urx_q  <= '0;
      ury_q  <= '0;
      step_q <= '0;
      for (int v = 0; v < VERTS; v++)
        for (int a = 0; a < AXIS; a++)
          tri_q[v][a] <= '0;
      for (int c = 0; c < COLORS; c++)
        color_q[c] <= '0;
    end else begin
      state <= state_nxt;
      x0_q  <= x0_nxt;
      y_q   <= y_nxt;
      if (accept) begin
        llx_q  <= bus.box_R13S[0][0];
        urx_q  <= bus.box_R13S[1][0];
        ury_q  <= bus.box_R13S[1][1];
        step_q <= step_in;
        for (int v = 0; v < VERTS; v++)
          for (int a = 0; a < AXIS; a++)
            tri_q[v][a] <= bus.tri_R13S[v][a];
        for (int c = 0; c < COLORS; c++)
          color_q[c] <= bus.color_R13U[c];
      end
    end
  end

  // Positions hold their last value in WAIT; only the valids are forced low there.
  always_comb begin
    bus.halt_RnnnnL = (state == WAIT);
    bus.state_dbg   = (state == TEST);
    for (int v = 0; v < VERTS; v++)
      for (int a = 0; a < AXIS; a++)
        bus.tri_R14S[v][a] = tri_q[v][a];
    for (int c = 0; c < COLORS; c++)
      bus.color_R14U[c] = color_q[c];
    for (int i = 0; i < SAMPLES; i++) begin
      bus.sample_R14S[i][0] = lane_x[i];
      bus.sample_R14S[i][1] = y_q;
      bus.validSamp_R14H[i] = (state == TEST) && (lane_x[i] <= urx_q);
    end
  end

endmodule

// File: tb/tb_sample_iterator.sv
// Directed bench for sample_iterator: expected lane groups are queued when a
// triangle is issued and popped by a monitor whenever any lane is valid.
module tb_sample_iterator;

  localparam int SIGFIG  = 24;
  localparam int RADIX   = 10;
  localparam int VERTS   = 3;
  localparam int AXIS    = 3;
  localparam int COLORS  = 3;
  localparam int SAMPLES = 2;
  localparam int W       = 5 * SIGFIG + SAMPLES;

  localparam logic [3:0] MSAA1  = 4'b1000;
  localparam logic [3:0] MSAA4  = 4'b0100;
  localparam logic [3:0] MSAA16 = 4'b0010;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  int   halt_low;

  logic [W-1:0] exp_q[$];

  sample_iterator_if #(
    .SIGFIG(SIGFIG), .VERTS(VERTS), .AXIS(AXIS), .COLORS(COLORS), .SAMPLES(SAMPLES)
  ) bif ();

  sample_iterator #(
    .SIGFIG(SIGFIG), .RADIX(RADIX), .VERTS(VERTS), .AXIS(AXIS),
    .COLORS(COLORS), .SAMPLES(SAMPLES)
  ) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bif)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_grp(input int col, input int x0, input int x1, input int y,
                          input logic [SAMPLES-1:0] v);
    exp_q.push_back({SIGFIG'(col), SIGFIG'(x0), SIGFIG'(x1), SIGFIG'(y), SIGFIG'(y), v});
  endtask

  // Monitor: every cycle with any valid lane must match the head of the queue.
  always @(negedge clk) begin
    logic [W-1:0] act;
    logic [W-1:0] exp;
    if (bif.validSamp_R14H != '0) begin
      act = {bif.color_R14U[0], bif.sample_R14S[0][0], bif.sample_R14S[1][0],
             bif.sample_R14S[0][1], bif.sample_R14S[1][1], bif.validSamp_R14H};
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL grp_unexpected: got 0x%0h expected no group at %0t", act, $time);
      end else begin
        exp = exp_q.pop_front();
        check("grp", 128'(act), 128'(exp));
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic set_tri(input int col, input int llx, input int lly, input int urx,
                         input int ury, input logic [3:0] ss);
    for (int v = 0; v < VERTS; v++)
      for (int a = 0; a < AXIS; a++)
        bif.tri_R13S[v][a] = SIGFIG'(col * 16 + v * 3 + a);
    for (int c = 0; c < COLORS; c++)
      bif.color_R13U[c] = SIGFIG'(col + c);
    bif.box_R13S[0][0]    = SIGFIG'(llx);
    bif.box_R13S[0][1]    = SIGFIG'(lly);
    bif.box_R13S[1][0]    = SIGFIG'(urx);
    bif.box_R13S[1][1]    = SIGFIG'(ury);
    bif.subSample_RnnnnU  = ss;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!bif.halt_RnnnnL && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bif.halt_RnnnnL) begin
      n_checks++;
      n_fail++;
      $display("FAIL idle_timeout: got halt=0 expected halt=1 within 200 cycles");
    end
  endtask

  task automatic send(input int col, input int llx, input int lly, input int urx,
                      input int ury, input logic [3:0] ss);
    wait_idle();
    set_tri(col, llx, lly, urx, ury, ss);
    bif.validTri_R13H = 1'b1;
    @(posedge clk);
    #1;
    bif.validTri_R13H = 1'b0;
  endtask

  // Counts consecutive cycles with halt low, starting from the current cycle.
  task automatic count_halt_low(output int n);
    n = 0;
    while (!bif.halt_RnnnnL && n < 100) begin
      n++;
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    bif.validTri_R13H = 1'b0;
    set_tri(0, 0, 0, 0, 0, MSAA1);

    repeat (3) @(negedge clk);
    check("rst_halt", 128'(bif.halt_RnnnnL), 128'(1));
    check("rst_state", 128'(bif.state_dbg), 128'(0));
    check("rst_valid", 128'(bif.validSamp_R14H), 128'(0));
    check("rst_sample", 128'({bif.sample_R14S[0][0], bif.sample_R14S[1][0], bif.sample_R14S[1][1]}), 128'(0));
    check("rst_tri", 128'({bif.tri_R14S[0][0], bif.tri_R14S[2][2], bif.color_R14U[1]}), 128'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // 1: single group, then back to WAIT
    push_grp(11, 0, 1024, 0, 2'b11);
    send(11, 0, 0, 1024, 0, MSAA1);
    count_halt_low(halt_low);
    check("s1_halt_low", 128'(halt_low), 128'(1));
    check("s1_tri_hold", 128'(bif.tri_R14S[2][1]), 128'(11 * 16 + 7));
    check("s1_color_hold", 128'(bif.color_R14U[2]), 128'(13));

    // 2: 2x2 group walk with partial right-hand groups
    push_grp(21, 0, 1024, 0, 2'b11);
    push_grp(21, 2048, 3072, 0, 2'b01);
    push_grp(21, 0, 1024, 1024, 2'b11);
    push_grp(21, 2048, 3072, 1024, 2'b01);
    send(21, 0, 0, 2048, 1024, MSAA1);
    count_halt_low(halt_low);
    check("s2_halt_low", 128'(halt_low), 128'(4));
    check("s2_hold_pos", 128'({bif.sample_R14S[0][0], bif.sample_R14S[0][1]}),
          128'({SIGFIG'(2048), SIGFIG'(1024)}));

    // 3: MSAA4 half-pixel pitch
    push_grp(31, 0, 512, 0, 2'b11);
    push_grp(31, 0, 512, 512, 2'b11);
    send(31, 0, 0, 512, 512, MSAA4);
    count_halt_low(halt_low);
    check("s3_halt_low", 128'(halt_low), 128'(2));

    // 4: validTri held high across two triangles
    push_grp(41, 0, 1024, 0, 2'b11);
    push_grp(42, 0, 1024, 0, 2'b11);
    push_grp(42, 0, 1024, 1024, 2'b11);
    wait_idle();
    set_tri(41, 0, 0, 1024, 0, MSAA1);
    bif.validTri_R13H = 1'b1;
    @(posedge clk);
    #1;
    set_tri(42, 0, 0, 1024, 1024, MSAA1);
    check("s4_busy", 128'(bif.halt_RnnnnL), 128'(0));
    @(posedge clk);
    #1;
    check("s4_gap_halt", 128'(bif.halt_RnnnnL), 128'(1));
    check("s4_gap_valid", 128'(bif.validSamp_R14H), 128'(0));
    @(posedge clk);
    #1;
    bif.validTri_R13H = 1'b0;
    check("s4_second_accept", 128'(bif.halt_RnnnnL), 128'(0));
    count_halt_low(halt_low);
    check("s4_halt_low", 128'(halt_low), 128'(2));

    // 5: asynchronous reset during the second group
    push_grp(51, 0, 1024, 0, 2'b11);
    send(51, 0, 0, 2048, 1024, MSAA1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("s5_valid", 128'(bif.validSamp_R14H), 128'(0));
    check("s5_halt", 128'(bif.halt_RnnnnL), 128'(1));
    check("s5_zero", 128'({bif.sample_R14S[1][0], bif.sample_R14S[0][1], bif.tri_R14S[1][1], bif.color_R14U[0]}), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    push_grp(61, 1024, 1280, 2048, 2'b11);
    send(61, 1024, 2048, 1280, 2048, MSAA16);
    count_halt_low(halt_low);
    check("s5_new_halt_low", 128'(halt_low), 128'(1));

    // 6: inverted box is consumed and dropped
    wait_idle();
    set_tri(71, 2048, 0, 1024, 0, MSAA1);
    bif.validTri_R13H = 1'b1;
    @(posedge clk);
    #1;
    bif.validTri_R13H = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("s6_halt", 128'(bif.halt_RnnnnL), 128'(1));
      check("s6_valid", 128'(bif.validSamp_R14H), 128'(0));
    end
    check("s6_color_kept", 128'(bif.color_R14U[0]), 128'(61));

    repeat (5) @(negedge clk);
    check("queue_empty", 128'(exp_q.size()), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
